// File: rtl/i2d_core_defines.sv
// Shared i2d core definitions: instruction layout, opcodes, operand-use decode
// and the two NOP encodings the decode stage can insert.
package i2d_core_defines;

  typedef enum logic [5:0] {
    OPCODE_NOP  = 6'd0,
    OPCODE_ADD  = 6'd1,
    OPCODE_ADDC = 6'd2,
    OPCODE_SUB  = 6'd3,
    OPCODE_SUBC = 6'd4,
    OPCODE_MUL  = 6'd5,
    OPCODE_DIV  = 6'd6,
    OPCODE_AND  = 6'd7,
    OPCODE_OR   = 6'd8,
    OPCODE_LSL  = 6'd9,
    OPCODE_LSR  = 6'd10,
    OPCODE_ASL  = 6'd11,
    OPCODE_ASR  = 6'd12,
    OPCODE_NOT  = 6'd13,
    OPCODE_MOV  = 6'd14,
    OPCODE_LD   = 6'd15,
    OPCODE_ST   = 6'd16,
    OPCODE_BR   = 6'd17,
    OPCODE_JMP  = 6'd18,
    OPCODE_LDI  = 6'd19
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [3:0]  regd_cond;
    logic [3:0]  rega;
    logic [3:0]  regb;
    logic [13:0] imm;
  } instr_t;

  // The flush NOP carries imm=1 so execute can tell it apart from a hazard bubble.
  localparam instr_t FLUSH_NOP  = '{opcode: OPCODE_NOP, regd_cond: 4'd0, rega: 4'd0,
                                    regb: 4'd0, imm: 14'd1};
  localparam instr_t BUBBLE_NOP = '{opcode: OPCODE_NOP, regd_cond: 4'd0, rega: 4'd0,
                                    regb: 4'd0, imm: 14'd0};

  function automatic logic uses_rega(input instr_t i);
    case (i.opcode)
      OPCODE_ADD, OPCODE_ADDC, OPCODE_SUB, OPCODE_SUBC, OPCODE_MUL, OPCODE_DIV,
      OPCODE_AND, OPCODE_OR, OPCODE_LSL, OPCODE_LSR, OPCODE_ASL, OPCODE_ASR,
      OPCODE_NOT, OPCODE_MOV, OPCODE_LD, OPCODE_ST: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_regb(input instr_t i);
    case (i.opcode)
      OPCODE_ADD, OPCODE_ADDC, OPCODE_SUB, OPCODE_SUBC, OPCODE_MUL, OPCODE_DIV,
      OPCODE_AND, OPCODE_OR, OPCODE_LSL, OPCODE_LSR, OPCODE_ASL, OPCODE_ASR,
      OPCODE_ST: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// CORE_ID_BYPASS_EN makes a same-cycle write visible on the read ports.
module core_regfile #(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
`ifdef CORE_ID_BYPASS_EN
    if (we && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr == raddr_b) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/core_id.sv
// i2d instruction-decode stage: ID pipeline register, operand read, load-use
// hazard stall. Optional write-through bypass via CORE_ID_BYPASS_EN.
module core_id
  import i2d_core_defines::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  instr_t      if_instr,
  input  logic [31:0] if_pc,
  input  logic        id_halt,
  input  logic        flush,
  input  logic        wb,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_data,
  output instr_t      id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] rega_data,
  output logic [31:0] regb_data,
  output logic        if_stall
);

  logic        haz;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  core_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb && !id_halt),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (if_instr.rega),
    .raddr_b (if_instr.regb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    haz = (id_instr.opcode == OPCODE_LD) &&
          ((uses_rega(if_instr) && id_instr.regd_cond == if_instr.rega) ||
           (uses_regb(if_instr) && id_instr.regd_cond == if_instr.regb));
`ifndef CORE_ID_BYPASS_EN
    // Without bypass a same-cycle writeback is not yet readable; wait one edge.
    haz = haz || (wb && ((uses_rega(if_instr) && wb_addr == if_instr.rega) ||
                         (uses_regb(if_instr) && wb_addr == if_instr.regb)));
`endif
  end

  assign if_stall = haz && !flush && !id_halt && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr  <= BUBBLE_NOP;
      id_pc     <= '0;
      rega_data <= '0;
      regb_data <= '0;
    end else if (id_halt) begin
      id_instr  <= id_instr;
    end else if (flush) begin
      id_instr  <= FLUSH_NOP;
      rega_data <= '0;
      regb_data <= '0;
    end else if (haz) begin
      id_instr  <= BUBBLE_NOP;
      rega_data <= '0;
      regb_data <= '0;
    end else begin
      id_instr  <= if_instr;
      id_pc     <= if_pc;
      rega_data <= rd_a;
      regb_data <= rd_b;
    end
  end

endmodule

// File: tb/tb_core_id.sv
// Self-checking bench for core_id: directed scenarios plus random traffic,
// compared against a register-array reference model of the decode stage.
module tb_core_id;
  import i2d_core_defines::*;

  logic        clk = 1'b0;
  logic        rst, id_halt, flush, wb;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data, if_pc;
  logic [31:0] if_instr;
  instr_t      id_instr;
  logic [31:0] id_pc, rega_data, regb_data;
  logic        if_stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [31:0] m_instr, m_pc, m_a, m_b;
  logic [31:0] m_regs [16];

  core_id #(.NREGS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .id_halt   (id_halt),
    .flush     (flush),
    .wb        (wb),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .rega_data (rega_data),
    .regb_data (regb_data),
    .if_stall  (if_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb, 14'h0};
  endfunction

  // Instruction word layout: [31:26] opcode, [25:22] regd, [21:18] rega, [17:14] regb
  function automatic logic reads_a(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return op inside {OPCODE_ADD, OPCODE_ADDC, OPCODE_SUB, OPCODE_SUBC, OPCODE_MUL,
                      OPCODE_DIV, OPCODE_AND, OPCODE_OR, OPCODE_LSL, OPCODE_LSR,
                      OPCODE_ASL, OPCODE_ASR, OPCODE_NOT, OPCODE_MOV, OPCODE_LD,
                      OPCODE_ST};
  endfunction

  function automatic logic reads_b(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return reads_a(ins) && !(op inside {OPCODE_NOT, OPCODE_MOV, OPCODE_LD});
  endfunction

  function automatic logic depends_on(input logic [31:0] ins, input logic [3:0] r);
    return (reads_a(ins) && ins[21:18] == r) || (reads_b(ins) && ins[17:14] == r);
  endfunction

  function automatic logic model_haz();
    logic h;
    h = (m_instr[31:26] == OPCODE_LD) && depends_on(if_instr, m_instr[25:22]);
`ifndef CORE_ID_BYPASS_EN
    h = h || (wb && depends_on(if_instr, wb_addr));
`endif
    return h;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] r);
`ifdef CORE_ID_BYPASS_EN
    if (wb && wb_addr == r) return wb_data;
`endif
    return m_regs[r];
  endfunction

  task automatic model_edge();
    logic [31:0] va, vb;
    logic        h;
    if (rst) begin
      m_instr = '0; m_pc = '0; m_a = '0; m_b = '0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    end else if (!id_halt) begin
      h  = model_haz();
      va = model_read(if_instr[21:18]);
      vb = model_read(if_instr[17:14]);
      if (flush) begin
        m_instr = {6'(OPCODE_NOP), 26'd1}; m_a = '0; m_b = '0;
      end else if (h) begin
        m_instr = '0; m_a = '0; m_b = '0;
      end else begin
        m_instr = if_instr; m_pc = if_pc; m_a = va; m_b = vb;
      end
      if (wb) m_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic f, input logic w,
                      input logic [3:0] wa, input logic [31:0] wd,
                      input logic [31:0] ins, input logic [31:0] pc);
    @(negedge clk);
    rst = r; id_halt = h; flush = f; wb = w; wb_addr = wa; wb_data = wd;
    if_instr = ins; if_pc = pc;
    #1;
    chk("if_stall", {31'b0, if_stall}, {31'b0, model_haz() && !flush && !id_halt && !rst});
    @(posedge clk);
    model_edge();
    #1;
    chk("id_instr", id_instr, m_instr);
    chk("id_pc", id_pc, m_pc);
    chk("rega_data", rega_data, m_a);
    chk("regb_data", regb_data, m_b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [8];
    logic [31:0] ld5, add5, not5;
    ops = '{OPCODE_ADD, OPCODE_NOT, OPCODE_MOV, OPCODE_LD, OPCODE_ST,
            OPCODE_NOP, OPCODE_BR, OPCODE_SUB};
    rst = 1'b1; id_halt = 1'b0; flush = 1'b0; wb = 1'b0;
    wb_addr = '0; wb_data = '0; if_instr = '0; if_pc = '0;
    m_instr = '0; m_pc = '0; m_a = '0; m_b = '0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    ld5  = mk(OPCODE_LD, 4'd5, 4'd0, 4'd0);
    add5 = mk(OPCODE_ADD, 4'd1, 4'd5, 4'd2);
    not5 = mk(OPCODE_NOT, 4'd1, 4'd2, 4'd5);

    // Reset with ADD presented, then read a few registers back as zero
    step(1, 0, 0, 0, 0, 0, add5, 32'h100);
    step(1, 0, 0, 0, 0, 0, add5, 32'h100);
    chk("rst_instr", id_instr, 32'h0);
    step(0, 0, 0, 0, 0, 0, mk(OPCODE_ADD, 0, 4'd9, 4'd15), 32'h104);

    // Writeback then MOV reading r3
    step(0, 0, 0, 1, 4'd3, 32'hDEAD_BEEF, mk(OPCODE_MOV, 4'd4, 4'd3, 4'd0), 32'h108);
    step(0, 0, 0, 0, 4'd0, 0, mk(OPCODE_MOV, 4'd4, 4'd3, 4'd0), 32'h108);
    chk("wb_read", rega_data, 32'hDEAD_BEEF);

    // Load-use: one bubble then issue; NOT on regb does not stall
    step(0, 0, 0, 0, 0, 0, ld5, 32'h10C);
    step(0, 0, 0, 0, 0, 0, add5, 32'h110);
    chk("bubble", id_instr, 32'h0);
    chk("bubble_pc", id_pc, 32'h10C);
    step(0, 0, 0, 0, 0, 0, add5, 32'h110);
    chk("issue", id_instr, add5);
    step(0, 0, 0, 0, 0, 0, ld5, 32'h114);
    step(0, 0, 0, 0, 0, 0, not5, 32'h118);
    chk("not_nostall", id_instr, not5);

    // Flush coinciding with a load-use hazard
    step(0, 0, 0, 0, 0, 0, ld5, 32'h11C);
    step(0, 0, 1, 0, 0, 0, add5, 32'h120);
    chk("flush_nop", id_instr, 32'h0000_0001);
    chk("flush_pc", id_pc, 32'h11C);

    // Halt for 3 cycles with toggling inputs, then the write lands
    step(0, 0, 0, 0, 0, 0, mk(OPCODE_ADD, 4'd2, 4'd3, 4'd3), 32'h124);
    for (int i = 0; i < 3; i++)
      step(0, 1, i[0], ~i[0], 4'd7, 32'h1234_0000 + i, mk(OPCODE_MOV, 4'd1, 4'd7, 4'd0), 32'h200 + i);
    chk("halt_pc", id_pc, 32'h124);
    step(0, 0, 0, 1, 4'd7, 32'hCAFE_F00D, mk(OPCODE_NOP, 0, 0, 0), 32'h128);
    step(0, 0, 0, 0, 4'd0, 0, mk(OPCODE_MOV, 4'd1, 4'd7, 4'd0), 32'h12C);
    chk("halt_wb", rega_data, 32'hCAFE_F00D);

    // Reset during a stall cycle
    step(0, 0, 0, 0, 0, 0, ld5, 32'h130);
    step(1, 0, 0, 0, 0, 0, add5, 32'h134);
    chk("rst_mid", id_instr, 32'h0);
    step(0, 0, 0, 0, 0, 0, mk(OPCODE_ADD, 0, 4'd3, 4'd7), 32'h138);

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = {ops[$urandom_range(7)], 4'($urandom_range(3)), 4'($urandom_range(3)),
             4'($urandom_range(3)), 14'($urandom)};
      step($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
           $urandom_range(1) == 1, 4'($urandom_range(3)), $urandom, ins, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_id.md
# core_id

Instruction-decode stage of the i2d core, between fetch and execute. It captures the fetched instruction and PC into the ID pipeline register and reads both source operands from the 16×32 architectural register file it owns. The writeback port from the execute stage updates that register file. It also detects load-use hazards, stalls fetch, and inserts bubbles; on a branch flush it inserts a marked NOP.

## Interface
- `NREGS`, default 16: number of architectural registers; the address width is fixed at 4.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_instr`  in  instr_t(32)  fetched instruction.
- `if_pc`  in  32  PC of `if_instr`.
- `id_halt`  in  1  global pipeline halt; all ID state holds.
- `flush`  in  1  branch or redirect; the ID register loads a flush NOP.
- `wb`  in  1  writeback enable from execute.
- `wb_addr`  in  4  writeback register index.
- `wb_data`  in  32  writeback value.
- `id_instr`  out  instr_t(32)  registered instruction to execute.
- `id_pc`  out  32  registered PC.
- `rega_data`  out  32  registered operand A (register `if_instr.rega`).
- `regb_data`  out  32  registered operand B (register `if_instr.regb`).
- `if_stall`  out  1  combinational; holds fetch for this cycle.

## Operation
- Register file: 16 × 32 flops, all cleared on `rst`.
  - Written at the clock edge when `wb=1` and `id_halt=0`.
  - A write during halt is dropped; execute holds `wb` stable while halted, so it re-presents the write after the halt.
- Hazard:
  - Condition: `haz = (id_instr.opcode==OPCODE_LD) && ((uses_rega(if_instr) && id_instr.regd_cond==if_instr.rega) || (uses_regb(if_instr) && id_instr.regd_cond==if_instr.regb))`.
  - `uses_rega`: ADD, ADDC, SUB, SUBC, MUL, DIV, AND, OR, LSL, LSR, ASL, ASR, NOT, MOV, LD, ST.
  - `uses_regb`: the same list minus NOT, MOV and LD.
- `if_stall = haz && !flush && !id_halt`.
- Next-state priority at each edge:
  1. `rst`: `id_instr=0`, `id_pc=0`, `rega_data=0`, `regb_data=0`, all registers 0.
  2. `id_halt`: all outputs and registers hold.
  3. `flush`: `id_instr={OPCODE_NOP,26'(1)}`, operands 0, `id_pc` holds.
  4. `haz`: `id_instr={OPCODE_NOP,26'(0)}` (bubble, distinguishable from the flush NOP), operands 0, `id_pc` holds.
  5. Otherwise: `id_instr=if_instr`, `id_pc=if_pc`, operands = register-file read, bypassed per Configuration.
- Operand read is combinational from the register-file flops and is captured at the same edge as `id_instr`.
- `if_stall` is never asserted in the cycle after a bubble from the same LD: the LD has moved to execute, so `haz` clears.
- `if_stall` must not be asserted when `rst=1`.

## Timing
- ID latency: 1 cycle, `if_instr` to `id_instr`/operands.
- Register write to visible read:
  - 0 cycles with bypass enabled.
  - Without bypass, the write is visible on the next edge, covered by the extra stall described in Configuration.
- Load-use costs exactly 1 bubble cycle.
- Simultaneous events:
  - `flush` with `haz`: flush wins and `if_stall=0`.
  - `id_halt` with anything: hold.
  - `rst` mid-stall: outputs clear and `if_stall` drops the same cycle.
  - A write to the same address in consecutive cycles: the last write wins.

## Configuration
- `CORE_ID_BYPASS_EN` defined:
  - Each operand read compares its address with `wb_addr`.
  - On a match with `wb=1`, the operand takes `wb_data` in the same cycle (write-through).
- Not defined:
  - No bypass mux; reads return the stored value.
  - `haz` additionally includes `wb && (uses_rega(if_instr) && wb_addr==if_instr.rega || uses_regb(if_instr) && wb_addr==if_instr.regb)`, giving a 1-bubble RAW stall on writeback.

## Structure
- Shared package `i2d_core_defines.sv` holds:
  - `instr_t` (fields `opcode`, `regd_cond`, `rega`, `regb`, imm).
  - The `OPCODE_*` enum.
  - `uses_rega`/`uses_regb` functions.
  - `FLUSH_NOP`/`BUBBLE_NOP` constants.
- One sub-module `core_regfile`:
  - 16×32 registers, two combinational read ports, one write port.
  - Bypass under `CORE_ID_BYPASS_EN`.
- `core_id` holds the hazard logic and the pipeline register.

## Test plan
- Reset: hold `rst=1` for 2 cycles with `if_instr=ADD`. Then `id_instr=0`, `id_pc=0`, both operands 0, `if_stall=0`; reading any register gives 0.
- Writeback and read: `wb=1`, `wb_addr=3`, `wb_data=32'hDEAD_BEEF`, then `if_instr=MOV` with `rega=3`.
  - With bypass and same cycle: `rega_data=32'hDEAD_BEEF` after 1 edge.
  - Without bypass: 1 bubble, then the same value.
- Load-use: `id_instr=LD` with `regd=5`, `if_instr=ADD` with `rega=5`. `if_stall=1` for 1 cycle, `id_instr=BUBBLE_NOP`, then ADD issues with `if_stall=0`. The same case with NOT reading `regb=5` gives no stall.
- Flush with hazard: the load-use setup above with `flush=1`. `id_instr={OPCODE_NOP,26'(1)}`, `if_stall=0`, `id_pc` unchanged.
- Halt: `id_halt=1` for 3 cycles while `if_instr`/`wb` toggle. `id_instr`, `id_pc` and the operands are unchanged and no register is written; after release, the pending write lands.
- Reset mid-stall: assert `rst` in the stall cycle. `if_stall=0` in the same cycle and all outputs 0 after the edge.
